layer1_streamer: RTL and testbench

Downstream neighbour of the atrous-convolution/max-pool engine. Once that engine has finished filling the layer-1 result memory (32×32 words, `csel`=1 bank), this block reads all 1024 words in raster order. It streams them out over a valid/ready interface with backpressure, and accumulates a running sum and maximum for result checking and host readout.

---
 rtl/layer1_pkg.sv | 21 ++
 rtl/layer1_streamer_fifo2.sv | 71 +++++++
 rtl/layer1_streamer.sv | 149 ++++++++++++++
 tb/tb_layer1_streamer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/layer1_pkg.sv
// Shared constants, FSM state type and small helpers for the layer-1 result streamer.
package layer1_pkg;

  localparam int L1_DEPTH = 1024;
  localparam int DATA_W   = 13;
  localparam int ADDR_W   = 12;
  localparam int SUM_W    = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Q9.4 words carry their fraction in the low nibble.
  function automatic logic frac_nonzero(input logic [3:0] nib);
    return |nib;
  endfunction

endpackage

// File: rtl/layer1_streamer_fifo2.sv
// Two-entry synchronous FIFO holding captured words plus their last tag.
module fifo2
  import layer1_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] entry0_q, entry0_d;
  logic [W-1:0] entry1_q, entry1_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (push_i) begin
      if (wptr_q) begin
        entry1_d = din_i;
      end else begin
        entry0_d = din_i;
      end
      wptr_d = ~wptr_q;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_i) begin
      rptr_d = ~rptr_q;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_q <= {W{1'b0}};
      entry1_q <= {W{1'b0}};
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = rptr_q ? entry1_q : entry0_q;
  assign count_o = count_q;

endmodule

// File: rtl/layer1_streamer.sv
// Reads the layer-1 result bank in raster order and streams it over valid/ready,
// accumulating sum, max and a fractional-bit flag over accepted beats.
module layer1_streamer
  import layer1_pkg::*;
#(
  parameter int DEPTH = L1_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              csel,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] max,
  output logic              frac_err,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1'b1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic                crd_q, crd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic                frac_q, frac_d;
  logic                issue_s;
  logic                pop_s;
  logic [1:0]          count_s;
  logic [DATA_W:0]     head_s;

  // crd_q doubles as the in-flight flag: its data is captured on the next edge.
  fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (crd_q),
    .pop_i   (pop_s),
    .din_i   ({caddr_q == LAST_ADDR, cdata_rd}),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign m_valid = (count_s != 2'd0);
  assign m_data  = head_s[DATA_W-1:0];
  assign m_last  = head_s[DATA_W];
  assign pop_s   = m_valid & m_ready;

  // Sequencing, read issue under the 2-credit rule, and beat accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    caddr_d = caddr_q;
    crd_d   = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    max_d   = max_q;
    frac_d  = frac_q;
    issue_s = ({1'b0, count_s} + {2'b00, crd_q}) < (3'd2 + {2'b00, pop_s});
    if (pop_s) begin
      sum_d  = sum_q + SUM_W'(m_data);
      max_d  = (m_data > max_q) ? m_data : max_q;
      frac_d = frac_q | frac_nonzero(m_data[3:0]);
    end else begin
      sum_d  = sum_q;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          crd_d   = 1'b1;
          caddr_d = {ADDR_W{1'b0}};
          cnt_d   = ONE_ADDR;
          sum_d   = {SUM_W{1'b0}};
          max_d   = {DATA_W{1'b0}};
          frac_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_s) begin
          crd_d   = 1'b1;
          caddr_d = cnt_q;
          cnt_d   = cnt_q + ONE_ADDR;
          state_d = (cnt_q == LAST_ADDR) ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if ((count_s == 2'd0) && !crd_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      caddr_q <= {ADDR_W{1'b0}};
      crd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {SUM_W{1'b0}};
      max_q   <= {DATA_W{1'b0}};
      frac_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      caddr_q <= caddr_d;
      crd_q   <= crd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      frac_q  <= frac_d;
    end
  end

  assign busy     = busy_q;
  assign csel     = busy_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign max      = max_q;
  assign frac_err = frac_q;

endmodule

// File: tb/tb_layer1_streamer.sv
// Scoreboard bench for layer1_streamer: directed memory images, expected beats queued per pass.
module tb_layer1_streamer;
  import layer1_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy, csel, crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              m_valid, m_ready, m_last;
  logic [DATA_W-1:0] m_data;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] max;
  logic              frac_err, done;

  logic [DATA_W-1:0] mem [0:L1_DEPTH-1];
  logic [DATA_W:0]   exp_q [$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0, issued = 0, accepted = 0, bubbles = 0, over_cnt = 0;
  int done_cnt = 0, done_cyc = 0, last_cyc = 0;
  int rdy_mode = 0, stall_left = 0;
  bit stall_done = 0, in_pass = 0, prev_stall = 0;
  logic [DATA_W:0] prev_beat;
  logic [15:0] lfsr = 16'hACE1;

  layer1_streamer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .csel(csel), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .sum(sum), .max(max), .frac_err(frac_err), .done(done)
  );

  assign cdata_rd = mem[caddr_rd[9:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Downstream ready: always-on, or LFSR pattern with one 20-cycle stall at beat 100.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        m_ready = 1'b1;
      end else begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
        end else if (accepted == 100 && !stall_done) begin
          m_ready = 1'b0;
          stall_left = 19;
          stall_done = 1'b1;
        end else begin
          m_ready = lfsr[0] | lfsr[3];
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall hold and credit bound.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (crd) issued++;
      if (issued - accepted > 2) over_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_pass && rdy_mode == 0 && accepted > 0 && accepted < L1_DEPTH && !m_valid) bubbles++;
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_hold", 32'({m_last, m_data}), 32'(prev_beat));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL beat_queue: got beat 0x%0h, expected no beat", m_data);
        end else begin
          chk("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
        end
        if (m_last) last_cyc = cyc;
        accepted++;
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  task automatic run_pass(input int mode, input bit pulses, input bit do_reset,
                          input logic [SUM_W-1:0] esum, input logic [DATA_W-1:0] emax,
                          input logic efrac);
    int  done_before;
    bit  got_done, p5, p500;
    exp_q.delete();
    for (int i = 0; i < L1_DEPTH; i++) exp_q.push_back({i == L1_DEPTH - 1, mem[i]});
    issued = 0; accepted = 0; bubbles = 0; over_cnt = 0;
    stall_done = 1'b0; stall_left = 0; rdy_mode = mode;
    done_before = done_cnt;
    got_done = 1'b0; p5 = 1'b0; p500 = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_pass = 1'b1;
    chk("start_ctrl", 32'({busy, csel, crd}), 32'd7);
    chk("start_addr", 32'(caddr_rd), 32'd0);
    chk("start_sum_clr", 32'(sum), 32'd0);
    chk("start_max_clr", 32'(max), 32'd0);
    @(posedge clk); #1;
    chk("first_valid", 32'(m_valid), 32'd1);
    chk("first_data", 32'(m_data), 32'(mem[0]));
    for (int c = 0; c < 6000 && !got_done; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (do_reset && accepted >= 300) begin
        reset = 1'b1;
        #2;
        chk("rst_ctrl", 32'({busy, csel, crd, m_valid, m_last, frac_err, done}), 32'd0);
        chk("rst_addr", 32'(caddr_rd), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_max", 32'(max), 32'd0);
        #1 reset = 1'b0;
        prev_stall = 1'b0;
        in_pass = 1'b0;
        exp_q.delete();
        issued = 0; accepted = 0;
        return;
      end
      if (pulses && accepted >= 5 && !p5) begin
        start = 1'b1; p5 = 1'b1;
      end else if (pulses && accepted >= 500 && !p500) begin
        start = 1'b1; p500 = 1'b1;
      end
      if (done_cnt != done_before) got_done = 1'b1;
    end
    start = 1'b0;
    in_pass = 1'b0;
    if (!got_done) begin
      n_total++;
      $display("FAIL done_timeout: got no done pulse, expected one within 6000 cycles");
    end
    chk("beats", 32'(accepted), 32'(L1_DEPTH));
    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    chk("sum", 32'(sum), 32'(esum));
    chk("max", 32'(max), 32'(emax));
    chk("frac_err", 32'(frac_err), 32'(efrac));
    chk("done_latency", 32'(done_cyc - last_cyc), 32'd2);
    chk("credit_bound", 32'(over_cnt), 32'd0);
    if (mode == 0) chk("no_bubbles", 32'(bubbles), 32'd0);
    @(posedge clk); #1;
    chk("busy_drop", 32'({busy, csel}), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt - done_before), 32'd1);
    chk("idle_quiet", 32'({busy, crd}), 32'd0);
    chk("frac_sticky", 32'(frac_err), 32'(efrac));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < L1_DEPTH; i++) mem[i] = 13'(((i % 512) << 4));
    #3;
    chk("rst_ctrl", 32'({busy, csel, crd, m_valid, m_last, frac_err, done}), 32'd0);
    chk("rst_addr", 32'(caddr_rd), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_max", 32'(max), 32'd0);
    #10 reset = 1'b0;

    run_pass(0, 1'b0, 1'b0, 23'd4186112, 13'd8176, 1'b0);
    run_pass(1, 1'b0, 1'b0, 23'd4186112, 13'd8176, 1'b0);

    for (int i = 0; i < L1_DEPTH; i++) mem[i] = 13'd0;
    mem[37] = 13'h0015;
    run_pass(0, 1'b0, 1'b0, 23'd21, 13'd21, 1'b1);

    for (int i = 0; i < L1_DEPTH; i++) mem[i] = 13'(((i % 512) << 4));
    run_pass(0, 1'b1, 1'b0, 23'd4186112, 13'd8176, 1'b0);
    run_pass(1, 1'b0, 1'b1, 23'd4186112, 13'd8176, 1'b0);
    repeat (3) @(posedge clk);
    run_pass(1, 1'b0, 1'b0, 23'd4186112, 13'd8176, 1'b0);

    for (int i = 0; i < L1_DEPTH; i++) mem[i] = 13'h1FF0;
    run_pass(0, 1'b0, 1'b0, 23'd8372224, 13'd8176, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
